// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the stack controller: default sizes, operation
// encodings, FSM state encodings and a helper for the occupancy width.
// -----------------------------------------------------------------------------
package stack_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 32;

    typedef logic [1:0] op_t;

    localparam op_t OP_PUSH  = 2'd0;
    localparam op_t OP_POP   = 2'd1;
    localparam op_t OP_PEEK  = 2'd2;
    localparam op_t OP_CLEAR = 2'd3;

    // Controller states. INIT is the reset state and clears the stack once.
    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_PUSH   = 3'd2;
    localparam logic [2:0] ST_POP    = 3'd3;
    localparam logic [2:0] ST_CAP    = 3'd4;
    localparam logic [2:0] ST_REPUSH = 3'd5;
    localparam logic [2:0] ST_CLR    = 3'd6;

    // Occupancy counter must hold 0..DEPTH inclusive.
    function automatic int depth_w(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// -----------------------------------------------------------------------------
// stack_ctrl_if
// Host-side request/response bus of the stack controller.
//   req/op/wdata         : request, driven by the host (master)
//   ready/done/rdata     : handshake and POP/PEEK result, driven by controller
//   err_ovf/err_unf      : one-cycle refusal pulses
//   depth                : current stack occupancy
// -----------------------------------------------------------------------------
interface stack_ctrl_if
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);

    logic                      req;
    op_t                       op;
    logic [WIDTH-1:0]          wdata;
    logic                      ready;
    logic                      done;
    logic [WIDTH-1:0]          rdata;
    logic                      err_ovf;
    logic                      err_unf;
    logic [$clog2(DEPTH):0]    depth;

    modport master (
        output req, op, wdata,
        input  ready, done, rdata, err_ovf, err_unf, depth
    );

    modport slave (
        input  req, op, wdata,
        output ready, done, rdata, err_ovf, err_unf, depth
    );

endinterface

// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
// Sequencer in front of an external LIFO. Accepts PUSH/POP/PEEK/CLEAR from the
// host bus, tracks occupancy, refuses overflow/underflow, and drives the LIFO
// control pins. PEEK is a POP followed by a re-PUSH of the captured word.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : host request/response interface (slave side)
//   stk_en    : LIFO enable
//   stk_rst   : LIFO synchronous clear (active high)
//   stk_rw    : 1 push, 0 pop
//   stk_din   : data to LIFO
//   stk_dout  : LIFO output, registered by the LIFO on the pop edge
// -----------------------------------------------------------------------------
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    stack_ctrl_if.slave      bus,
    output logic             stk_en,
    output logic             stk_rst,
    output logic             stk_rw,
    output logic [WIDTH-1:0] stk_din,
    input  logic [WIDTH-1:0] stk_dout
);

    localparam int DW = depth_w(DEPTH);

    logic [2:0]        state;
    op_t               op_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [WIDTH-1:0]  rdata_q;
    logic [DW-1:0]     depth_q;
    logic              done_q;
    logic              ovf_q;
    logic              unf_q;

    logic              full;
    logic              empty;

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_INIT;
            op_q    <= OP_PUSH;
            wdata_q <= '0;
            rdata_q <= '0;
            depth_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            // Completion/error flags are single-cycle pulses.
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            case (state)
                ST_INIT: begin
                    depth_q <= '0;
                    state   <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.req) begin
                        op_q    <= bus.op;
                        wdata_q <= bus.wdata;
                        case (bus.op)
                            OP_PUSH: begin
                                if (full) begin
                                    ovf_q  <= 1'b1;
                                    done_q <= 1'b1;
                                end else begin
                                    state <= ST_PUSH;
                                end
                            end
                            OP_POP, OP_PEEK: begin
                                if (empty) begin
                                    unf_q  <= 1'b1;
                                    done_q <= 1'b1;
                                end else begin
                                    state <= ST_POP;
                                end
                            end
                            default: state <= ST_CLR;
                        endcase
                    end
                end
                ST_PUSH: begin
                    depth_q <= depth_q + 1'b1;
                    done_q  <= 1'b1;
                    state   <= ST_IDLE;
                end
                ST_POP: begin
                    depth_q <= depth_q - 1'b1;
                    state   <= ST_CAP;
                end
                ST_CAP: begin
                    // LIFO registered the popped word on the previous edge.
                    rdata_q <= stk_dout;
                    if (op_q == OP_PEEK) begin
                        state <= ST_REPUSH;
                    end else begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                ST_REPUSH: begin
                    depth_q <= depth_q + 1'b1;
                    done_q  <= 1'b1;
                    state   <= ST_IDLE;
                end
                ST_CLR: begin
                    depth_q <= '0;
                    done_q  <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // LIFO controls depend on state and registers only, never on the live
    // request, so the LIFO sees clean signals for a whole cycle.
    always_comb begin
        stk_en  = 1'b0;
        stk_rst = 1'b0;
        stk_rw  = 1'b0;
        stk_din = '0;
        case (state)
            ST_INIT, ST_CLR: begin
                stk_en  = 1'b1;
                stk_rst = 1'b1;
            end
            ST_PUSH: begin
                stk_en  = 1'b1;
                stk_rw  = 1'b1;
                stk_din = wdata_q;
            end
            ST_POP: begin
                stk_en = 1'b1;
            end
            ST_REPUSH: begin
                stk_en  = 1'b1;
                stk_rw  = 1'b1;
                stk_din = rdata_q;
            end
            default: ;
        endcase
    end

    assign bus.ready   = (state == ST_IDLE);
    assign bus.done    = done_q;
    assign bus.rdata   = rdata_q;
    assign bus.err_ovf = ovf_q;
    assign bus.err_unf = unf_q;
    assign bus.depth   = depth_q;

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, stack word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, stack slot count; occupancy counter width is log2(DEPTH)+1.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  operation request, sampled only when ready=1.
REQ-006 SHALL have port op  input  2  operation code: 0 PUSH, 1 POP, 2 PEEK, 3 CLEAR.
REQ-007 SHALL have port wdata  input  WIDTH  PUSH data.
REQ-008 SHALL have port ready  output  1  high only in IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  WIDTH  POP/PEEK result, held until the next POP/PEEK completion.
REQ-011 SHALL have port err_ovf  output  1  one-cycle pulse: PUSH refused, stack full.
REQ-012 SHALL have port err_unf  output  1  one-cycle pulse: POP/PEEK refused, stack empty.
REQ-013 SHALL have port depth  output  log2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port stk_en  output  1  stack enable.
REQ-015 SHALL have port stk_rst  output  1  stack clear, active-high, synchronous at the stack.
REQ-016 SHALL have port stk_rw  output  1  0 read/pop, 1 write/push.
REQ-017 SHALL have port stk_din  output  WIDTH  data to the stack.
REQ-018 SHALL have port stk_dout  input  WIDTH  stack output, registered by the stack on the pop edge.

Function
REQ-019 SHALL implement FSM states INIT, IDLE, PUSH, POP, CAP, REPUSH, CLR.
REQ-020 SHALL decode stk_* outputs from state and internal registers only; no combinational path from req/op/wdata to stk_*.
REQ-021 SHALL hold stk_en=0 in IDLE and CAP.
REQ-022 SHALL, on an edge with req=1 in IDLE, register op and wdata and transition per op, unless an error condition applies.
REQ-023 SHALL, when PUSH is requested with depth==DEPTH, stay in IDLE and pulse err_ovf and done in the next cycle, with no stack access.
REQ-024 SHALL, when POP or PEEK is requested with depth==0, stay in IDLE and pulse err_unf and done in the next cycle, with no stack access.
REQ-025 SHALL, in PUSH, drive stk_en=1, stk_rw=1, stk_din=registered wdata; on the next edge: depth+1, go to IDLE, done=1.
REQ-026 SHALL, in POP (entered for both POP and PEEK), drive stk_en=1, stk_rw=0; on the next edge: depth-1, go to CAP.
REQ-027 SHALL, on the CAP edge, load rdata<=stk_dout; for POP: go to IDLE with done=1; for PEEK: go to REPUSH.
REQ-028 SHALL, in REPUSH, drive stk_en=1, stk_rw=1, stk_din=rdata; on the next edge: depth+1, go to IDLE, done=1.
REQ-029 SHALL, in CLR and INIT, drive stk_en=1, stk_rst=1; on the next edge: depth=0, go to IDLE, done=1 for CLR only.
REQ-030 Latencies, counted from the accept edge to the cycle done is high: PUSH 1 edge later, POP 2, PEEK 3, CLEAR 1, error 0.
REQ-031 SHALL accept a new request in the same cycle done is high, since ready=1 in that cycle.
REQ-032 SHALL ignore req while ready=0; it is neither queued nor errored.
REQ-033 SHALL keep depth within 0..DEPTH at all times; PEEK leaves depth unchanged at completion.

Reset
REQ-034 SHALL, on rst=0 (asynchronous), set state=INIT, depth=0, rdata=0, and done, err_ovf, err_unf, ready, stk_rw, stk_din all 0.
REQ-035 SHALL drive stk_en=1 and stk_rst=1 during and after reset until the first edge after reset release, so a stack interrupted mid-operation is cleared.
REQ-036 SHALL make ready first rise in the cycle after the INIT edge.

Structure
REQ-037 SHALL place the op encodings, the state enumeration, and the WIDTH/DEPTH defaults in shared package stack_pkg.
REQ-038 SHALL have no sub-module; the LIFO is instantiated beside stack_ctrl by the parent.

Verification
REQ-039 Reset release -> one INIT cycle with stk_rst=1, stk_en=1; then ready=1, depth=0.
REQ-040 PUSH 0x1111, 0x2222, then POP -> rdata=0x2222 with done 2 edges after accept; depth=1.
REQ-041 PUSH 0xABCD, then PEEK -> rdata=0xABCD, done 3 edges after accept; depth=1; a following POP returns 0xABCD.
REQ-042 32 PUSHes, then a 33rd PUSH -> err_ovf pulse, depth stays 32, no stk_en; 32 POPs return values in LIFO order; a further POP -> err_unf pulse.
REQ-043 Back-to-back requests with req held high -> a new request is accepted in each done cycle, none lost; req pulses while ready=0 have no effect.
REQ-044 rst pulsed low in the middle of a PEEK -> outputs reset immediately; INIT clears the stack; depth=0; the next POP -> err_unf pulse.
